spi_dac_rx: RTL
===============

Name: spi_dac_rx

Overview:
- SPI responder for the 16-bit MCP4911-style DAC write frame: {0, BUF, GA_N, SHDN_N, D[9:0], 2'bxx}, MSB first.
- Samples the SPI lines in the 50 MHz system clock domain and holds frames in an input register. A falling LDAC edge transfers the input register to the output register.
- Serves two roles: loopback checker for the DAC driver path in simulation and on the FPGA, and DAC emulator feeding on-chip logic.

Parameters:
- SYNC_STAGES, 2, flip-flop depth of the input synchronizer on each of sck/cs/sdi/ld (minimum 2).
- FRAME_BITS, 16, number of sck rising edges per valid frame.
- DATA_BITS, 10, DAC data width; data field is frame bits [11:2].

Ports:
- clk  in  1  50 MHz system clock.
- rst_n  in  1  asynchronous active-low reset.
- dac_sck  in  1  SPI clock; idles low; data sampled on rising edge.
- dac_cs  in  1  chip select, active low.
- dac_sdi  in  1  serial data, MSB first.
- dac_ld  in  1  LDAC, active low; its falling edge transfers data.
- data_out  out  DATA_BITS  output-register DAC value.
- buf_en  out  1  BUF bit of the last transferred frame.
- gain_x1  out  1  GA_N bit of the last transferred frame.
- active  out  1  SHDN_N bit of the last transferred frame.
- frame_valid  out  1  one-clk pulse: good frame stored in input register.
- frame_err  out  1  one-clk pulse: frame rejected.
- ld_pulse  out  1  one-clk pulse: output register updated.
- busy  out  1  high while a frame is in progress (cs low seen).

Behaviour:
- Reset: all outputs 0; input register 0; pending flag 0; bit counter 0; FSM in IDLE.
- Sync and edges:
  - Each input passes through SYNC_STAGES flip-flops, then one edge-detect register.
  - Edge latency from pin to internal event is SYNC_STAGES+1 clk.
  - sdi is sampled from the same synchronizer stage as sck.
- FSM states: IDLE, SHIFT, DONE, ERR.
  - IDLE: sck edges are ignored. A cs fall goes to SHIFT with counter cleared and busy=1.
  - SHIFT: each sck rise shifts sdi into shreg[0] and increments the counter. Counter reaching FRAME_BITS goes to DONE. A cs rise before that pulses frame_err and goes to IDLE.
  - DONE: a further sck rise goes to ERR. On cs rise:
    - shreg[15]=1 (not a write command): pulse frame_err, input register unchanged.
    - Otherwise: load input register {BUF, GA_N, SHDN_N, D}, set pending, pulse frame_valid.
    - Then go to IDLE with busy=0.
  - ERR: wait for cs rise, then pulse frame_err and go to IDLE.
- LDAC:
  - On an ld fall while synced cs is high, copy the input register to data_out/buf_en/gain_x1/active, pulse ld_pulse, and clear pending.
  - An ld fall while cs is low is ignored (no pulse).
  - An ld fall with pending=0 still re-transfers the input register and pulses ld_pulse.
- Simultaneous cs rise and ld fall in the same clk:
  - The frame commit happens first.
  - The transfer uses the newly committed frame: data_out shows the new value the next clk, and frame_valid and ld_pulse assert together.
- Minimum timing: supports sck up to clk/8. Behaviour at faster sck is not defined.
- Reset mid-frame discards the partial frame and produces no pulses after reset.

Decomposition:
- Shared package spi_dac_pkg holds:
  - the frame field positions (CMD_MSB=15, BUF_BIT=14, GA_BIT=13, SHDN_BIT=12, DATA_MSB=11, DATA_LSB=2);
  - FRAME_BITS and DATA_BITS;
  - the FSM state encoding.
- One sub-module, sync_edge: an N-stage synchronizer with rise/fall pulse outputs. It is instantiated for each of the four inputs.

Test Plan:
- Frame 0x7A5C (BUF=1, GA_N=1, SHDN_N=1, D=0x297) followed by an ld low pulse -> frame_valid once, then ld_pulse; data_out=0x297, buf_en=gain_x1=active=1.
- cs raised after 9 sck edges -> frame_err once, no frame_valid; a subsequent ld fall leaves data_out at its previous value.
- 17 sck edges in one cs window -> frame_err at cs rise; input register unchanged.
- Frame 0xF000 (command bit 1) -> frame_err; a later ld fall leaves data_out unchanged.
- cs rise and ld fall on the same synced clk with D=0x3FF -> frame_valid and ld_pulse in the same cycle; data_out=0x3FF on the next clk.
- rst_n low after 8 sck edges, then released and a full frame 0x7004 sent -> no pulse for the aborted frame; data_out=0x001 after ld.

Source files
------------

// File: rtl/spi_dac_pkg.sv
// Shared frame layout and FSM encoding for the MCP4911-style DAC write-frame responder.
// Field positions assume the 16-bit frame {0, BUF, GA_N, SHDN_N, D[9:0], 2'bxx}.
package spi_dac_pkg;
  localparam int FRAME_BITS = 16;
  localparam int DATA_BITS  = 10;

  localparam int CMD_MSB  = 15;
  localparam int BUF_BIT  = 14;
  localparam int GA_BIT   = 13;
  localparam int SHDN_BIT = 12;
  localparam int DATA_MSB = 11;
  localparam int DATA_LSB = 2;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE,
    ERR
  } state_t;
endpackage

// File: rtl/spi_dac_rx_sync_edge.sv
// N-stage synchronizer plus one edge-detect register; rise/fall appear STAGES+1 clk after the pin.
// No backpressure: one-clk pulses, the consumer must act in the cycle they are high.
module sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic sync,
  output logic rise,
  output logic fall
);
  logic [STAGES-1:0] chain;
  logic              prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= '0;
      prev  <= 1'b0;
    end else begin
      chain <= {chain[STAGES-2:0], din};
      prev  <= chain[STAGES-1];
    end
  end

  assign sync = chain[STAGES-1];
  assign rise = sync & ~prev;
  assign fall = ~sync & prev;
endmodule

// File: rtl/spi_dac_rx.sv
// SPI responder for DAC write frames: input register on good frame, output register on LDAC fall.
// No backpressure; status outputs are one-clk pulses registered one clk after the synced edge.
module spi_dac_rx #(
  parameter int SYNC_STAGES = 2,
  parameter int FRAME_BITS  = spi_dac_pkg::FRAME_BITS,
  parameter int DATA_BITS   = spi_dac_pkg::DATA_BITS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 dac_sck,
  input  logic                 dac_cs,
  input  logic                 dac_sdi,
  input  logic                 dac_ld,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 buf_en,
  output logic                 gain_x1,
  output logic                 active,
  output logic                 frame_valid,
  output logic                 frame_err,
  output logic                 ld_pulse,
  output logic                 busy
);
  import spi_dac_pkg::*;

  localparam int CW = $clog2(FRAME_BITS + 1);
  localparam logic [CW-1:0] LAST = CW'(FRAME_BITS - 1);

  logic sck_sync, sck_rise, sck_fall;
  logic cs_sync, cs_rise, cs_fall;
  logic sdi_sync, sdi_rise, sdi_fall;
  logic ld_sync, ld_rise, ld_fall;

  sync_edge #(.STAGES(SYNC_STAGES)) u_sck (.clk(clk), .rst_n(rst_n), .din(dac_sck),
    .sync(sck_sync), .rise(sck_rise), .fall(sck_fall));
  sync_edge #(.STAGES(SYNC_STAGES)) u_cs (.clk(clk), .rst_n(rst_n), .din(dac_cs),
    .sync(cs_sync), .rise(cs_rise), .fall(cs_fall));
  sync_edge #(.STAGES(SYNC_STAGES)) u_sdi (.clk(clk), .rst_n(rst_n), .din(dac_sdi),
    .sync(sdi_sync), .rise(sdi_rise), .fall(sdi_fall));
  sync_edge #(.STAGES(SYNC_STAGES)) u_ld (.clk(clk), .rst_n(rst_n), .din(dac_ld),
    .sync(ld_sync), .rise(ld_rise), .fall(ld_fall));

  state_t                  state, state_nx;
  logic [CW-1:0]           cnt, cnt_nx;
  logic [FRAME_BITS-1:0]   shreg, shreg_nx;
  logic                    commit, reject, xfer, pending;
  logic [DATA_BITS+2:0]    in_reg, frame_fields, xfer_src;
  logic                    unused_sigs;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    shreg_nx = shreg;
    commit   = 1'b0;
    reject   = 1'b0;
    case (state)
      IDLE: begin
        if (cs_fall) begin
          state_nx = SHIFT;
          cnt_nx   = '0;
        end
      end
      SHIFT: begin
        if (cs_rise) begin
          reject   = 1'b1;
          state_nx = IDLE;
        end else if (sck_rise) begin
          shreg_nx = {shreg[FRAME_BITS-2:0], sdi_sync};
          cnt_nx   = cnt + 1'b1;
          if (cnt == LAST) state_nx = DONE;
        end
      end
      DONE: begin
        if (cs_rise) begin
          if (shreg[CMD_MSB]) reject = 1'b1;
          else                commit = 1'b1;
          state_nx = IDLE;
        end else if (sck_rise) begin
          state_nx = ERR;
        end
      end
      ERR: begin
        if (cs_rise) begin
          reject   = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign frame_fields = {shreg[BUF_BIT], shreg[GA_BIT], shreg[SHDN_BIT], shreg[DATA_MSB:DATA_LSB]};
  // A commit and an LDAC fall in the same clk must transfer the frame being committed.
  assign xfer     = ld_fall & cs_sync;
  assign xfer_src = commit ? frame_fields : in_reg;
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      shreg       <= '0;
      in_reg      <= '0;
      pending     <= 1'b0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      ld_pulse    <= 1'b0;
      data_out    <= '0;
      buf_en      <= 1'b0;
      gain_x1     <= 1'b0;
      active      <= 1'b0;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      shreg       <= shreg_nx;
      frame_valid <= commit;
      frame_err   <= reject;
      ld_pulse    <= xfer;
      if (commit) in_reg <= frame_fields;
      if (xfer)        pending <= 1'b0;
      else if (commit) pending <= 1'b1;
      if (xfer) {buf_en, gain_x1, active, data_out} <= xfer_src;
    end
  end

  assign unused_sigs = ^{sck_sync, sck_fall, sdi_rise, sdi_fall, ld_sync, ld_rise, pending};
endmodule
